// File: rtl/eth_tx_hdr_insert.sv
`default_nettype none
// ============================================================================
// eth_tx_hdr_insert : overwrites the source MAC of outgoing 64-bit AXIS frames
// and, when ETH_TX_PAD_EN is defined, pads runt frames to MIN_BEATS beats.
// Revision 1.0
// ============================================================================
module eth_tx_hdr_insert #(
    parameter int DW        = 64,
    parameter int MIN_BEATS = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [47:0]   mac_addr_i,
    input  logic          insert_en_i,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_tlast,
    input  logic          s_tuser,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          m_tuser,
    output logic [31:0]   frames_o
);

`ifdef ETH_TX_PAD_EN
    typedef enum logic [1:0] {ST_FIRST, ST_SECOND, ST_BODY, ST_PAD} state_t;
`else
    typedef enum logic [1:0] {ST_FIRST, ST_SECOND, ST_BODY} state_t;
`endif

    state_t        state;
    logic [47:0]   mac;
    logic          ins;
    logic          out_ready;
    logic          accept;
    logic [DW-1:0] beat;

    assign out_ready = !m_tvalid || m_tready;
`ifdef ETH_TX_PAD_EN
    assign s_tready  = out_ready && !rst_i && (state != ST_PAD);
`else
    assign s_tready  = out_ready && !rst_i;
`endif
    assign accept    = s_tvalid && s_tready;

`ifdef ETH_TX_PAD_EN
    localparam logic [8:0] MIN_B = 9'(MIN_BEATS);

    logic [7:0] cnt;
    logic [7:0] cnt_base;
    logic [7:0] cnt_inc;
    logic [8:0] next_cnt;
    logic       last_ok;
    logic       pad_w1;

    // Counter reads as zero on the frame-start beat so a stale count never leaks in.
    assign cnt_base = (state == ST_FIRST) ? 8'd0 : cnt;
    assign cnt_inc  = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
    assign next_cnt = {1'b0, cnt_base} + 9'd1;
    assign last_ok  = (next_cnt >= MIN_B);
`endif

    // The frame-start beat uses the live MAC/enable, since they are captured on this same beat.
    always_comb begin
        beat = s_tdata;
        case (state)
            ST_FIRST:  if (insert_en_i) beat[63:48] = mac_addr_i[15:0];
            ST_SECOND: if (ins)         beat[31:0]  = mac[47:16];
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_FIRST;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            mac      <= '0;
            ins      <= 1'b0;
`ifdef ETH_TX_PAD_EN
            cnt      <= '0;
            pad_w1   <= 1'b0;
`endif
        end else if (accept) begin
            m_tvalid <= 1'b1;
            m_tdata  <= beat;
            m_tuser  <= s_tuser;
            if (state == ST_FIRST) begin
                mac <= mac_addr_i;
                ins <= insert_en_i;
            end
`ifdef ETH_TX_PAD_EN
            cnt <= cnt_inc;
`endif
            if (s_tlast) begin
`ifdef ETH_TX_PAD_EN
                m_tlast <= last_ok;
                state   <= last_ok ? ST_FIRST : ST_PAD;
                // A single-beat frame never carried word1, so the first pad beat gets its insert.
                pad_w1  <= (state == ST_FIRST);
`else
                m_tlast <= 1'b1;
                state   <= ST_FIRST;
`endif
            end else begin
                m_tlast <= 1'b0;
                state   <= (state == ST_FIRST) ? ST_SECOND : ST_BODY;
            end
        end
`ifdef ETH_TX_PAD_EN
        else if (state == ST_PAD && out_ready) begin
            m_tvalid <= 1'b1;
            m_tuser  <= 1'b0;
            m_tdata  <= (pad_w1 && ins) ? {32'h0, mac[47:16]} : '0;
            m_tlast  <= last_ok;
            pad_w1   <= 1'b0;
            cnt      <= cnt_inc;
            if (last_ok) state <= ST_FIRST;
        end
`endif
        else if (out_ready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            frames_o <= '0;
        else if (m_tvalid && m_tready && m_tlast)
            frames_o <= frames_o + 32'd1;
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_hdr_insert.sv
`default_nettype none
// Scoreboard bench for eth_tx_hdr_insert: expected beats are queued at stimulus
// time and popped by an independent output monitor.
module tb_eth_tx_hdr_insert;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [47:0] mac_addr_i;
    logic        insert_en_i;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic [31:0] frames_o;

    int    checks = 0;
    int    errors = 0;
    int    exp_frames = 0;
    beat_t q[$];
    logic  ignore = 1'b0;
    logic  rand_ready = 1'b0;
    logic  ready_level = 1'b1;

    logic [63:0] fw [8] = '{64'hAAAA_FFFF_FFFF_FFFF, 64'h3210_E200_BBBB_BBBB,
                            64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                            64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000,
                            64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    logic        fu [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] tx_d [32];
    logic        tx_u [32];

    localparam logic [47:0] MAC_A = 48'h2070_9800_1032;
    localparam logic [47:0] MAC_B = 48'h0A0B_0C0D_0E0F;

    eth_tx_hdr_insert #(.DW(64), .MIN_BEATS(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .mac_addr_i(mac_addr_i), .insert_en_i(insert_en_i),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .frames_o(frames_o)
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic l, input logic u);
        beat_t b;
        b.d = d; b.l = l; b.u = u;
        q.push_back(b);
    endtask

    // Output monitor: pops one expected beat per downstream handshake.
    logic        prev_stall = 1'b0;
    logic [65:0] prev_beat;
    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("axis_hold", {m_tvalid, m_tdata, m_tlast}, {1'b1, prev_beat[65:1]});
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tdata, m_tlast, m_tuser};
            if (m_tvalid && m_tready && !ignore) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h with empty queue", m_tdata);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("out_beat", {m_tdata, m_tlast, m_tuser}, {e.d, e.l, e.u});
                end
            end
        end
    end

    // Downstream ready: directed level, or random with occasional long stalls.
    initial begin
        int stall = 0;
        int r;
        m_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rand_ready) begin
                m_tready = ready_level;
            end else if (stall > 0) begin
                m_tready = 1'b0;
                stall--;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 4) begin
                    stall = $urandom_range(0, 49);
                    m_tready = 1'b0;
                end else begin
                    m_tready = (r >= 25);
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic l, input logic u);
        int n = 0;
        s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_tready stuck at %b, required 1", s_tready);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(posedge clk);
            if (gaps) #1;
            send_beat(tx_d[i], (i == n - 1), tx_u[i]);
        end
        exp_frames++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || m_tvalid) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d beats still queued, required 0", name, q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_frames"}, 66'(frames_o), 66'(exp_frames));
    endtask

    task automatic load_fw(input int n);
        for (int i = 0; i < n; i++) begin
            tx_d[i] = fw[i];
            tx_u[i] = fu[i];
        end
    endtask

    task automatic push_t1(input int last_idx);
        push(64'h1032_FFFF_FFFF_FFFF, last_idx == 0, fu[0]);
        push(64'h3210_E200_2070_9800, last_idx == 1, fu[1]);
        for (int i = 2; i <= last_idx; i++) push(fw[i], i == last_idx, fu[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; mac_addr_i = MAC_A; insert_en_i = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {m_tvalid, m_tdata, m_tlast}, 66'd0);
        chk("rst_misc", {32'd0, m_tuser, s_tready, frames_o}, 66'd0);
        @(negedge clk); rst_i = 1'b0;
        @(posedge clk); #1;

        // Insert enabled, full-length frame.
        load_fw(8);
        push_t1(7);
        send_frame(8, 1'b0);
        drain("insert_on");

        // Insert disabled: frame unchanged.
        insert_en_i = 1'b0;
        for (int i = 0; i < 8; i++) push(fw[i], i == 7, fu[i]);
        send_frame(8, 1'b0);
        drain("insert_off");

        // Three-beat runt.
        insert_en_i = 1'b1;
        load_fw(3);
`ifdef ETH_TX_PAD_EN
        push(64'h1032_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        push(64'h3210_E200_2070_9800, 1'b0, 1'b0);
        push(fw[2], 1'b0, 1'b1);
        for (int i = 3; i < 8; i++) push(64'h0, i == 7, 1'b0);
        send_frame(3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("pad_s_tready", 66'(s_tready), 66'd0);
        end
        @(negedge clk);
        chk("post_pad_s_tready", 66'(s_tready), 66'd1);
`else
        push(64'h1032_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        push(64'h3210_E200_2070_9800, 1'b0, 1'b0);
        push(fw[2], 1'b1, 1'b1);
        send_frame(3, 1'b0);
`endif
        drain("runt3");

        // Single-beat frame.
        load_fw(1);
`ifdef ETH_TX_PAD_EN
        push(64'h1032_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        push(64'h0000_0000_2070_9800, 1'b0, 1'b0);
        for (int i = 2; i < 8; i++) push(64'h0, i == 7, 1'b0);
`else
        push(64'h1032_FFFF_FFFF_FFFF, 1'b1, 1'b0);
`endif
        send_frame(1, 1'b0);
        drain("single_beat");

        // MAC changes after frame start: the captured MAC must still be used.
        load_fw(8);
        push_t1(7);
        send_beat(fw[0], 1'b0, fu[0]);
        mac_addr_i = MAC_B;
        for (int i = 1; i < 8; i++) send_beat(fw[i], i == 7, fu[i]);
        exp_frames++;
        drain("mid_change");

        // Reset in the middle of a frame.
        ignore = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(fw[i], 1'b0, fu[i]);
        s_tdata = fw[3]; s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0;
        @(negedge clk); #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_valid", {m_tvalid, s_tready, m_tlast}, 66'd0);
        chk("midrst_frames", 66'(frames_o), 66'd0);
        s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        q.delete();
        exp_frames = 0;
        @(posedge clk); #1;
        ignore = 1'b0;
        chk("postrst_frames", 66'(frames_o), 66'd0);

        push(64'h0E0F_FFFF_FFFF_FFFF, 1'b0, fu[0]);
        push(64'h3210_E200_0A0B_0C0D, 1'b0, fu[1]);
        for (int i = 2; i < 8; i++) push(fw[i], i == 7, fu[i]);
        send_frame(8, 1'b0);
        drain("after_reset");

        // Random backpressure and source gaps over 100 frames.
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            int          n;
            logic [63:0] m64;
            logic [63:0] d;
            m64 = {$urandom, $urandom};
            mac_addr_i  = m64[47:0];
            insert_en_i = 1'($urandom_range(0, 1));
            n = $urandom_range(8, 20);
            for (int i = 0; i < n; i++) begin
                d = {$urandom, $urandom};
                tx_d[i] = d;
                tx_u[i] = 1'($urandom_range(0, 1));
                if (insert_en_i && i == 0) d[63:48] = m64[15:0];
                if (insert_en_i && i == 1) d[31:0]  = m64[47:16];
                push(d, i == n - 1, tx_u[i]);
            end
            send_frame(n, 1'b1);
        end
        drain("backpressure");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
